cond_select_pipe: RTL and testbench
===================================

Name: cond_select_pipe

Overview:
- Parameterised, pipelined N-way conditional-select unit; successor to the single-bit-select `?:` operator block.
- Selects one of NCH source words by an index, with programmable modes:
  - plain select;
  - agreement bypass (all sources equal → output them regardless of select);
  - hold-on-out-of-range.
- Results are queued in a 2-entry output buffer behind a valid/ready handshake.
- Sits in datapath-translation regression designs as the sequential reference for generalised `?:` trees.

Parameters:
- WIDTH, 1, bits per source word and per result.
- NCH, 2, number of source channels (≥2).
- SELW, 1, select index width; must satisfy 2**SELW ≥ NCH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat offered.
- in_ready  output  1  unit can accept a beat this cycle.
- sel  input  SELW  channel index, sampled on accept.
- mode  input  2  0=PLAIN, 1=AGREE, 2=HOLD, 3=reserved (behaves as PLAIN).
- src  input  NCH*WIDTH  concatenated sources; channel k = src[k*WIDTH +: WIDTH].
- out_valid  output  1  buffer head valid.
- out_ready  input  1  consumer takes head this cycle.
- out_data  output  WIDTH  head result.
- out_agree  output  1  head result came from agreement bypass.
- out_oob  output  1  head beat had sel ≥ NCH.

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset state:
  - buffer count = 0;
  - out_valid = 0, out_data = 0, out_agree = 0, out_oob = 0;
  - in_ready = 1;
  - last-result register = 0.
- Accept and pop:
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
- Result computation (combinational on the accepted beat):
  - oob = (sel ≥ NCH).
  - eq_all = all NCH channels bitwise identical. Compare with 4-state identity semantics (`===`).
  - PLAIN / reserved: result = src[sel]; if oob, result = 0.
  - AGREE: if eq_all, result = channel 0 and agree = 1. Otherwise PLAIN rules apply, agree = 0.
  - HOLD: if oob, result = last-result. Otherwise result = src[sel].
- Last-result register: loads the computed result on every accept, including in HOLD-oob (value unchanged).
- Buffer:
  - 2-entry FIFO of {data, agree, oob}.
  - in_ready = (count < 2), driven from registered count only; no combinational path from out_ready.
  - out_valid = (count > 0); outputs show the head entry.
  - Latency: a beat accepted in cycle t is visible at the outputs in cycle t+1 when the buffer was empty.
- Count transitions:
  - accept only → +1;
  - pop only → −1;
  - both → unchanged (only possible at count = 1);
  - count = 2 blocks accepts.
  - Pop at count = 0 is ignored.
- Ordering: FIFO order is strictly preserved; no reordering, no drops.
- While out_valid = 0, out_data / out_agree / out_oob hold 0.
- Reset asserted mid-stream: buffered beats are discarded and last-result clears on the next edge. Beats offered in that cycle are not accepted.
- sel, mode, src are don't-care when not accepting.

Decomposition:
- Shared include header holds mode encodings (MODE_PLAIN=0, MODE_AGREE=1, MODE_HOLD=2) and the buffer-entry field layout.
- Sub-module `cond_select_core`: purely combinational. Inputs sel/mode/src/last; outputs result/agree/oob.
- Top level holds the FIFO, count and last-result register.

Test Plan (WIDTH=4, NCH=3, SELW=2):
- PLAIN, src={4'h3,4'h2,4'h1}, sel=1, out_ready=1 → next cycle out_data=4'h2, agree=0, oob=0.
- AGREE, all channels 4'hA, sel=2 → out_data=4'hA, agree=1; then channel 2 = 4'hB, sel=2 → out_data=4'hB, agree=0.
- HOLD:
  - accept sel=0 with channel 0 = 4'h5;
  - then sel=3 → out_data=4'h5, oob=1;
  - PLAIN sel=3 → out_data=0, oob=1.
- Backpressure: out_ready=0, offer 3 beats → in_ready drops after 2. Raise out_ready → results 1, 2, 3 emerge in order, none lost.
- Steady stream with count=1 and simultaneous accept+pop each cycle → count stays 1, one result per cycle.
- Reset pulse with count=2 and last=4'h7 → next cycle out_valid=0, in_ready=1. HOLD sel=3 then yields out_data=0.

Source files
------------

// File: rtl/cond_select_pipe_pkg.sv
// Shared definitions for the conditional-select pipeline: mode encodings and
// the bit layout of one output-buffer entry {data, agree, oob}.
package cond_select_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_PLAIN = 2'd0,
    MODE_AGREE = 2'd1,
    MODE_HOLD  = 2'd2,
    MODE_RSVD  = 2'd3   // treated exactly like MODE_PLAIN
  } mode_e;

  // Buffer entry layout, LSB first: oob flag, agree flag, then the data word.
  localparam int ENT_OOB_BIT   = 0;
  localparam int ENT_AGREE_BIT = 1;
  localparam int ENT_DATA_LSB  = 2;

  // Total entry width for a given data width.
  function automatic int ent_width(input int data_w);
    return data_w + ENT_DATA_LSB;
  endfunction

endpackage

// File: rtl/cond_select_core.sv
// Purely combinational N-way select with agreement bypass and
// hold-on-out-of-range. The caller supplies the last accepted result.
module cond_select_core
  import cond_select_pipe_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int NCH   = 2,
  parameter int SELW  = 1
) (
  input  logic [SELW-1:0]      sel_i,
  input  logic [1:0]           mode_i,
  input  logic [NCH*WIDTH-1:0] src_i,
  input  logic [WIDTH-1:0]     last_i,
  output logic [WIDTH-1:0]     result_o,
  output logic                 agree_o,
  output logic                 oob_o
);

  logic [WIDTH-1:0] chosen;
  logic             eq_all;

  // Pick the indexed channel (zero when no channel matches, i.e. out of
  // range) and check whether every channel is identical to channel 0.
  always_comb begin
    chosen = '0;
    eq_all = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (32'(sel_i) == k) chosen = src_i[k*WIDTH +: WIDTH];
      if (src_i[k*WIDTH +: WIDTH] !== src_i[WIDTH-1:0]) eq_all = 1'b0;
    end
  end

  assign oob_o = (32'(sel_i) >= 32'(NCH));

  // Apply the mode: agreement overrides the index, hold replaces an
  // out-of-range pick with the previous result; everything else is plain.
  always_comb begin
    result_o = chosen;
    agree_o  = 1'b0;
    case (mode_e'(mode_i))
      MODE_AGREE: begin
        if (eq_all) begin
          result_o = src_i[WIDTH-1:0];
          agree_o  = 1'b1;
        end
      end
      MODE_HOLD: begin
        if (oob_o) result_o = last_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cond_select_pipe.sv
// Pipelined conditional-select unit: computes one result per accepted beat
// and queues it in a 2-entry FIFO towards the consumer.
//
// Handshakes: a beat transfers on an interface exactly in a cycle where
// valid and ready are both high at the rising edge. in_ready depends only on
// the registered occupancy (never on out_ready); out_valid/out_* show the FIFO
// head and stay stable until it is taken.
module cond_select_pipe
  import cond_select_pipe_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int NCH   = 2,
  parameter int SELW  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic [1:0]           mode,
  input  logic [NCH*WIDTH-1:0] src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_agree,
  output logic                 out_oob
);

  localparam int EW = ent_width(WIDTH);

  logic [EW-1:0]    mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] last_q;

  logic [WIDTH-1:0] res;
  logic             res_agree, res_oob;
  logic [EW-1:0]    ent_new, head;
  logic             accept, pop;

  cond_select_core #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .SELW  (SELW)
  ) u_core (
    .sel_i    (sel),
    .mode_i   (mode),
    .src_i    (src),
    .last_i   (last_q),
    .result_o (res),
    .agree_o  (res_agree),
    .oob_o    (res_oob)
  );

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];

  // Pack the freshly computed result into a buffer entry.
  always_comb begin
    ent_new                            = '0;
    ent_new[ENT_DATA_LSB +: WIDTH]     = res;
    ent_new[ENT_AGREE_BIT]             = res_agree;
    ent_new[ENT_OOB_BIT]               = res_oob;
  end

  // Occupancy update; accept+pop together leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state: occupancy, pointers and the last-result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      last_q   <= '0;
    end else begin
      count_q <= count_d;
      if (accept) begin
        wr_ptr_q <= ~wr_ptr_q;
        last_q   <= res;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Entry storage; contents are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (accept && !reset) mem_q[wr_ptr_q] <= ent_new;
  end

  assign out_data  = out_valid ? head[ENT_DATA_LSB +: WIDTH] : '0;
  assign out_agree = out_valid & head[ENT_AGREE_BIT];
  assign out_oob   = out_valid & head[ENT_OOB_BIT];

endmodule

// File: tb/tb_cond_select_pipe.sv
// Directed bench for cond_select_pipe with WIDTH=4, NCH=3, SELW=2.
module tb_cond_select_pipe;

  localparam int WIDTH = 4;
  localparam int NCH   = 3;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [SELW-1:0]      sel = '0;
  logic [1:0]           mode = '0;
  logic [NCH*WIDTH-1:0] src = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [WIDTH-1:0]     out_data;
  logic                 out_agree;
  logic                 out_oob;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops   = 0;

  // Expected results in order: {data, agree, oob}
  logic [WIDTH+1:0] exp_q[$];

  cond_select_pipe #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .SELW  (SELW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .src       (src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_agree (out_agree),
    .out_oob   (out_oob)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every pop that will occur at the coming edge is compared
  // against the oldest expected entry; idle outputs must read zero.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 32'd1, 32'd0);
        end else begin
          chk("out_entry", {26'd0, out_data, out_agree, out_oob}, {26'd0, exp_q.pop_front()});
        end
      end else if (!out_valid) begin
        chk("idle_zero", {26'd0, out_data, out_agree, out_oob}, 32'd0);
      end
    end
  end

  // Offer one beat; called at posedge+#1, returns at posedge+#1 after accept.
  task automatic send(input logic [1:0] m, input logic [1:0] s,
                      input logic [11:0] sv, input logic [5:0] exp);
    bit done = 0;
    mode = m; sel = s; src = sv; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        exp_q.push_back(exp);
        done = 1;
      end else begin
        @(posedge clk);
      end
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk); #2;
    end
    chk("drain", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int p0, c0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  {28'd0, out_data},  32'd0);
    @(posedge clk); #1;

    // Plain select with one-cycle latency
    out_ready = 1'b1;
    send(2'd0, 2'd1, {4'h3, 4'h2, 4'h1}, {4'h2, 1'b0, 1'b0});
    @(negedge clk);
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_data",  {28'd0, out_data},  32'h2);
    @(posedge clk); #1;

    // Agreement bypass, then disagreement falls back to plain
    send(2'd1, 2'd2, {4'hA, 4'hA, 4'hA}, {4'hA, 1'b1, 1'b0});
    send(2'd1, 2'd2, {4'hB, 4'hA, 4'hA}, {4'hB, 1'b0, 1'b0});
    send(2'd1, 2'd3, {4'hC, 4'hC, 4'hC}, {4'hC, 1'b1, 1'b1});
    send(2'd1, 2'd3, {4'hC, 4'hD, 4'hC}, {4'h0, 1'b0, 1'b1});
    // Hold on out-of-range, plain out-of-range gives zero
    send(2'd2, 2'd0, {4'h0, 4'h0, 4'h5}, {4'h5, 1'b0, 1'b0});
    send(2'd2, 2'd3, {4'h9, 4'h9, 4'h9}, {4'h5, 1'b0, 1'b1});
    send(2'd0, 2'd3, {4'h1, 4'h2, 4'h3}, {4'h0, 1'b0, 1'b1});
    send(2'd3, 2'd2, {4'h6, 4'h2, 4'h3}, {4'h6, 1'b0, 1'b0});
    wait_drain();

    // Backpressure: two beats fill the buffer, third waits
    out_ready = 1'b0;
    p0 = pops;
    send(2'd0, 2'd0, 12'h001, {4'h1, 1'b0, 1'b0});
    send(2'd0, 2'd0, 12'h002, {4'h2, 1'b0, 1'b0});
    @(negedge clk);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head",     {28'd0, out_data}, 32'h1);
    @(posedge clk); #1;
    fork
      send(2'd0, 2'd0, 12'h003, {4'h3, 1'b0, 1'b0});
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_pops", pops - p0, 32'd3);

    // Steady stream: accept+pop every cycle at count=1
    c0 = cyc;
    fork
      for (int i = 0; i < 6; i++)
        send(2'd0, 2'(i % 3), {4'(i + 8), 4'(i + 4), 4'(i)},
             {4'(i + 4 * (i % 3)), 1'b0, 1'b0});
      begin
        @(posedge clk);
        repeat (5) begin
          @(negedge clk);
          chk("stream_flow", {30'd0, out_valid, in_ready}, 32'd3);
        end
      end
    join
    chk("stream_cycles", cyc - c0, 32'd6);
    wait_drain();

    // Reset with a full buffer and last=7; beat offered during reset is dropped
    out_ready = 1'b0;
    send(2'd0, 2'd0, 12'h007, {4'h7, 1'b0, 1'b0});
    send(2'd0, 2'd0, 12'h007, {4'h7, 1'b0, 1'b0});
    mode = 2'd0; sel = 2'd0; src = 12'h00E; in_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'd2, 2'd3, {4'h9, 4'h8, 4'h7}, {4'h0, 1'b0, 1'b1});
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "time limit");
  end

endmodule
